fetch_sequencer: RTL and testbench

Instruction-fetch and PC-sequencing stage of the WISC-15 single-issue core.
- Owns the PC and requests instruction words from instruction memory over a req/rdy handshake.
- Holds the fetched word for the decode/control stage and resolves the next PC from that stage's branch/call/ret/halt strobes and the Z/V/N flags.
- Sits directly upstream of the control unit: inst[15:12] is the opcode the control unit decodes.

---
 rtl/wisc_pkg.sv | 39 +++
 rtl/branch_cond.sv | 27 ++
 rtl/fetch_sequencer.sv | 98 +++++++++
 tb/tb_fetch_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC-15 opcodes, branch conditions and fetch states
package wisc_pkg;

  localparam int PC_W_DEF = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_LW   = 4'b0111;
  localparam logic [3:0] OP_SW   = 4'b1000;
  localparam logic [3:0] OP_LHB  = 4'b1001;
  localparam logic [3:0] OP_LLB  = 4'b1010;
  localparam logic [3:0] OP_RSV  = 4'b1011;
  localparam logic [3:0] OP_B    = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch condition evaluation from cond code and Z/V/N flags
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_z,
  input  logic       flag_v,
  input  logic       flag_n,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (cond)
      CC_NEQ:    take = !flag_z;
      CC_EQ:     take = flag_z;
      CC_GT:     take = !flag_z && !flag_n;
      CC_LT:     take = flag_n;
      CC_GTE:    take = flag_z || !flag_n;
      CC_LTE:    take = flag_n || flag_z;
      CC_OVFL:   take = flag_v;
      CC_UNCOND: take = 1'b1;
      default:   take = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - WISC-15 instruction fetch and PC sequencing stage
module fetch_sequencer
  import wisc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [15:0]     imem_data,
  output logic [15:0]     inst,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic            halt,
  input  logic            flag_z,
  input  logic            flag_v,
  input  logic            flag_n,
  input  logic [PC_W-1:0] ret_addr,
  input  logic            ex_stall,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     inst_q, inst_d;
  logic [PC_W-1:0] call_off, br_off;
  logic            br_take;

  assign pc_plus1 = pc_q + PC_W'(1);
  assign call_off = {{(PC_W-12){inst_q[11]}}, inst_q[11:0]};
  assign br_off   = {{(PC_W-9){inst_q[8]}}, inst_q[8:0]};

  branch_cond u_branch_cond (
    .cond   (inst_q[11:9]),
    .flag_z (flag_z),
    .flag_v (flag_v),
    .flag_n (flag_n),
    .take   (br_take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Strobes only matter on the edge that leaves EXEC; a stall keeps everything frozen.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_rdy) begin
          inst_d  = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!ex_stall) begin
          if (halt) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
            if (ret)                  pc_d = ret_addr;
            else if (call)            pc_d = pc_plus1 + call_off;
            else if (branch && br_take) pc_d = pc_plus1 + br_off;
            else                      pc_d = pc_plus1;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = (state_q == EXEC);
  assign pc         = pc_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_rdy = 1'b0;
  logic [15:0] imem_addr, imem_data = 16'h0000;
  logic [15:0] inst, pc, pc_plus1, ret_addr = 16'h0000;
  logic        inst_valid, halted;
  logic        branch = 0, call = 0, ret = 0, halt = 0;
  logic        flag_z = 0, flag_v = 0, flag_n = 0, ex_stall = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus1(pc_plus1),
    .branch(branch), .call(call), .ret(ret), .halt(halt),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .ret_addr(ret_addr), .ex_stall(ex_stall), .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  int lat = 0;
  int waited = 0;
  bit rdy_rand = 0;
  bit rdy_force = 0;

  // Reference model state
  int          m_pc;
  logic [15:0] m_inst;
  bit          m_valid, m_req, m_halted, m_started;

  typedef struct {
    logic [15:0] vpc;
    logic [15:0] vinst;
    bit          br, cl, rt;
    bit          z, v, n;
    logic [15:0] ra;
    logic [15:0] exp_next;
    logic [15:0] exp_pp1;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrap16(input int x);
    return ((x % 65536) + 65536) % 65536;
  endfunction

  function automatic int sext(input int val, input int bits);
    if (val >= (1 << (bits - 1))) return val - (1 << bits);
    return val;
  endfunction

  function automatic bit cond_true(input logic [2:0] c, input bit z, input bit v, input bit n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_inst = 16'h0000;
    m_valid = 0; m_req = 0; m_halted = 0; m_started = 0;
  endtask

  task automatic model_update();
    if (!rst_n) return;
    if (m_halted) return;
    if (!m_started) begin
      m_started = 1; m_req = 1;
    end else if (m_req) begin
      if (imem_rdy) begin
        m_inst = imem_data; m_req = 0; m_valid = 1;
      end
    end else if (m_valid && !ex_stall) begin
      m_valid = 0;
      if (halt) m_halted = 1;
      else begin
        m_req = 1;
        if (ret) m_pc = int'(ret_addr);
        else if (call) m_pc = wrap16(m_pc + 1 + sext(int'(m_inst[11:0]), 12));
        else if (branch && cond_true(m_inst[11:9], flag_z, flag_v, flag_n))
          m_pc = wrap16(m_pc + 1 + sext(int'(m_inst[8:0]), 9));
        else m_pc = wrap16(m_pc + 1);
      end
    end
  endtask

  task automatic compare_all();
    chk("imem_req", imem_req, m_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus1", pc_plus1, wrap16(m_pc + 1));
    chk("inst", inst, m_inst);
    chk("inst_valid", inst_valid, m_valid);
    chk("halted", halted, m_halted);
  endtask

  task automatic mem_drive();
    if (rdy_force) return;
    if (rdy_rand) begin
      imem_rdy  = 1'($urandom);
      imem_data = 16'($urandom);
      return;
    end
    if (imem_req) begin
      imem_rdy  = (waited >= lat);
      imem_data = mem[imem_addr];
      if (imem_rdy) waited = 0;
      else waited++;
    end else begin
      imem_rdy = 1'b0;
      waited   = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    mem_drive();
  endtask

  task automatic clear_strobes();
    branch = 0; call = 0; ret = 0; halt = 0;
    flag_z = 0; flag_v = 0; flag_n = 0; ex_stall = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    imem_rdy = 1'b0;
    waited   = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !inst_valid; i++) tick();
    chk("wait_valid", inst_valid, 1'b1);
  endtask

  task automatic jump_to(input logic [15:0] vpc);
    wait_valid(20);
    clear_strobes();
    ret = 1; ret_addr = vpc;
    tick();
    clear_strobes();
    wait_valid(20);
    chk("jump_pc", pc, vpc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

    vecs.push_back('{16'h0010, 16'hC3FC, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h000D, 16'h0011});
    vecs.push_back('{16'h0010, 16'hC3FC, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0011, 16'h0011});
    vecs.push_back('{16'hFFFF, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{16'h0100, 16'hD020, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0121, 16'h0101});
    vecs.push_back('{16'h0121, 16'hE000, 0, 0, 1, 0, 0, 0, 16'h0101, 16'h0101, 16'h0122});
    vecs.push_back('{16'h0200, 16'hCEFF, 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0300, 16'h0201});
    vecs.push_back('{16'h0300, 16'hC405, 1, 0, 0, 0, 0, 1, 16'h0000, 16'h0301, 16'h0301});
    vecs.push_back('{16'h0005, 16'hDFF0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'hFFF6, 16'h0006});
    vecs.push_back('{16'h0400, 16'hCC01, 1, 0, 0, 0, 1, 0, 16'h0000, 16'h0402, 16'h0401});
    vecs.push_back('{16'h0500, 16'hD010, 1, 1, 1, 0, 0, 0, 16'h1234, 16'h1234, 16'h0501});

    // Reset values, then three sequential ADDs on zero-wait memory
    clear_strobes();
    @(negedge clk);
    reset_dut();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", imem_req, 1'b0);
    tick();
    chk("a_req0", imem_req, 1'b1);
    chk("a_addr0", imem_addr, 16'h0000);
    tick();
    chk("a_valid0", inst_valid, 1'b1);
    tick();
    chk("a_addr1", imem_addr, 16'h0001);
    chk("a_novalid", inst_valid, 1'b0);
    tick();
    tick();
    chk("a_addr2", imem_addr, 16'h0002);
    tick();
    chk("a_valid2", inst_valid, 1'b1);
    chk("a_pc2", pc, 16'h0002);

    // Slow memory plus a stalled LW
    mem[16'h0030] = 16'h7123;
    lat = 3;
    clear_strobes();
    ret = 1; ret_addr = 16'h0030;
    tick();
    clear_strobes();
    for (int i = 0; i < 3; i++) begin
      chk("b_req_held", imem_req, 1'b1);
      chk("b_addr_held", imem_addr, 16'h0030);
      tick();
    end
    wait_valid(10);
    ex_stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("b_stall_inst", inst, 16'h7123);
      chk("b_stall_pc", pc, 16'h0030);
      chk("b_stall_valid", inst_valid, 1'b1);
    end
    ex_stall = 0;
    tick();
    chk("b_next_addr", imem_addr, 16'h0031);
    lat = 0;

    // Table of branch/call/ret/wrap vectors
    foreach (vecs[k]) begin
      mem[vecs[k].vpc] = vecs[k].vinst;
      jump_to(vecs[k].vpc);
      chk("v_pp1", pc_plus1, vecs[k].exp_pp1);
      branch = vecs[k].br; call = vecs[k].cl; ret = vecs[k].rt;
      flag_z = vecs[k].z; flag_v = vecs[k].v; flag_n = vecs[k].n;
      ret_addr = vecs[k].ra;
      tick();
      clear_strobes();
      chk("v_req", imem_req, 1'b1);
      chk("v_next", imem_addr, vecs[k].exp_next);
    end

    // Halt beats branch; HALT ignores memory activity
    mem[16'h0040] = 16'hF000;
    jump_to(16'h0040);
    halt = 1; branch = 1; flag_z = 1;
    tick();
    clear_strobes();
    rdy_rand = 1;
    for (int i = 0; i < 20; i++) begin
      ret = 1'($urandom); call = 1'($urandom); ret_addr = 16'($urandom);
      tick();
      chk("h_halted", halted, 1'b1);
      chk("h_pc", pc, 16'h0040);
      chk("h_req", imem_req, 1'b0);
    end
    rdy_rand = 0;
    clear_strobes();

    // Reset asserted mid-fetch with a late rdy
    reset_dut();
    wait_valid(10);
    mem[16'h0023] = 16'hA5A5;
    lat = 3;
    ret = 1; ret_addr = 16'h0023;
    tick();
    clear_strobes();
    chk("r_req", imem_req, 1'b1);
    chk("r_addr", imem_addr, 16'h0023);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r_pc_now", pc, 16'h0000);
    chk("r_req_now", imem_req, 1'b0);
    rdy_force = 1;
    imem_rdy = 1'b1; imem_data = 16'h1234;
    tick();
    chk("r_req_ign", imem_req, 1'b0);
    chk("r_valid_ign", inst_valid, 1'b0);
    chk("r_inst_ign", inst, 16'h0000);
    rdy_force = 0;
    imem_rdy = 1'b0;
    lat = 0;
    rst_n = 1'b1;
    tick();
    chk("r_restart_req", imem_req, 1'b1);
    chk("r_restart_addr", imem_addr, 16'h0000);

    // Randomized run against the model
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      branch   = ($urandom % 3) == 0;
      call     = ($urandom % 8) == 0;
      ret      = ($urandom % 8) == 0;
      halt     = ($urandom % 40) == 0;
      flag_z   = 1'($urandom);
      flag_v   = 1'($urandom);
      flag_n   = 1'($urandom);
      ret_addr = 16'($urandom);
      ex_stall = ($urandom % 4) == 0;
      lat      = $urandom % 3;
      if (m_halted || ($urandom % 300) == 0) reset_dut();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
